// File: rtl/wam_pkg.sv
// Shared constants for the whack-a-mole display path: game state codes, 7-segment
// glyphs (active-low {g,f,e,d,c,b,a}) and the digit count of the multiplexed display.
package wam_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_GAMEPLAY = 3'd1;
    localparam logic [2:0] ST_END      = 3'd2;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_I     = 7'b1111001;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam int NUM_DIGITS = 4;

    function automatic logic [6:0] state_glyph(input logic [2:0] st);
        case (st)
            ST_IDLE:     state_glyph = SEG_I;
            ST_GAMEPLAY: state_glyph = SEG_P;
            ST_END:      state_glyph = SEG_E;
            default:     state_glyph = SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 show a dash.
module seg7_decoder
    import wam_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        case (value)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/wam_display_driver.sv
// Scans score/lives/state onto a 4-digit common-anode display, one digit per refresh slot.
// Optional macro WAM_BLINK_ON_END_EN blinks the whole display while the end screen is shown.
module wam_display_driver
    import wam_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mole,
    input  logic [3:0] score,
    input  logic [3:0] lives,
    input  logic [2:0] state,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       led_mole
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [CNT_W-1:0] refresh_cnt;
    logic [IDX_W-1:0] digit_idx;
    logic [3:0]       snap_score;
    logic [3:0]       snap_lives;
    logic [2:0]       snap_state;

    logic             slot_end;
    logic [3:0]       dec_val;
    logic [6:0]       dec_seg;
    logic [6:0]       seg_next;
    logic [3:0]       an_scan;
    logic             blink_off;

    assign slot_end = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));

    // Digit mux: picks the value for the shared decoder, then overrides with blank/glyph.
    always_comb begin
        dec_val = 4'd0;
        case (digit_idx)
            2'd0: dec_val = (snap_score >= 4'd10) ? (snap_score - 4'd10) : snap_score;
            2'd1: dec_val = 4'd1;
            2'd2: dec_val = (snap_lives > 4'd9) ? 4'd9 : snap_lives;
            default: dec_val = 4'd0;
        endcase
    end

    seg7_decoder u_dec (
        .value (dec_val),
        .seg   (dec_seg)
    );

    always_comb begin
        seg_next = dec_seg;
        if (digit_idx == 2'd1 && snap_score < 4'd10)
            seg_next = SEG_BLANK;
        else if (digit_idx == 2'd3)
            seg_next = state_glyph(snap_state);
    end

    assign an_scan = ~(4'b0001 << digit_idx);

`ifdef WAM_BLINK_ON_END_EN
    localparam int BLINK_W = $clog2(BLINK_DIV);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    // The blink timer only runs while the end screen is latched, so each end screen starts visible.
    always_ff @(posedge clk) begin
        if (reset || snap_state != ST_END) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign blink_off = (snap_state == ST_END) && blink_phase;
`else
    assign blink_off = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            snap_score  <= '0;
            snap_lives  <= '0;
            snap_state  <= '0;
            an          <= 4'b1111;
            seg         <= SEG_BLANK;
            led_mole    <= 1'b0;
        end else begin
            if (slot_end) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx + 1'b1;
                // Latch new game values only at the frame boundary to avoid tearing.
                if (digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
                    snap_score <= score;
                    snap_lives <= lives;
                    snap_state <= state;
                end
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            an       <= blink_off ? 4'b1111 : an_scan;
            seg      <= seg_next;
            led_mole <= mole && (state == ST_GAMEPLAY);
        end
    end

endmodule
